// File: rtl/level_sequencer.sv
// level_sequencer: game-flow FSM that sets level, lives and per-row car configuration.
// Define LEVEL_SEQ_SPEEDUP_EN to make row speed scale with the level.
module level_sequencer #(
    parameter int NUM_ROWS    = 5,
    parameter int HOLD_FRAMES = 60,
    parameter int MAX_LEVEL   = 7,
    parameter int START_LIVES = 3,
    parameter int ROW0_Y      = 400,
    parameter int ROW_PITCH   = 40
) (
    input  logic                           frame_clk,
    input  logic                           Reset,
    input  logic                           win,
    input  logic                           lose,
    output logic [NUM_ROWS-1:0][2:0]       Row_Number_Cars,
    output logic [NUM_ROWS-1:0][7:0]       Row_Gap_Size,
    output logic [NUM_ROWS-1:0][5:0]       Row_Speed,
    output logic [NUM_ROWS-1:0]            Row_Direction,
    output logic [NUM_ROWS-1:0][10:0]      Row_Start_Y,
    output logic                           Row_Reload,
    output logic                           Rows_Frozen,
    output logic [2:0]                     Level,
    output logic [1:0]                     Lives,
    output logic                           Game_Over
);
    localparam int HW = $clog2(HOLD_FRAMES + 1);

    typedef enum logic [2:0] {LOAD, PLAY, WIN_HOLD, LOSE_HOLD, OVER} state_t;

    state_t                      state;
    logic [HW-1:0]               hold_cnt;
    logic                        win_q, lose_q;
    logic [NUM_ROWS-1:0][2:0]    cfg_cars;
    logic [NUM_ROWS-1:0][7:0]    cfg_gap;
    logic [NUM_ROWS-1:0][5:0]    cfg_speed;
    logic [NUM_ROWS-1:0]         cfg_dir;
    logic [NUM_ROWS-1:0][10:0]   cfg_y;

    wire win_e  = win & ~win_q;
    wire lose_e = lose & ~lose_q;

    always_comb begin
        cfg_cars  = '0;
        cfg_gap   = '0;
        cfg_speed = '0;
        cfg_dir   = '0;
        cfg_y     = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            cfg_cars[r]  = ((int'(Level) + r) >> 1) >= 3 ? 3'd4 : 3'(((int'(Level) + r) >> 1) + 1);
            cfg_gap[r]   = 8'(160 - 16 * int'(Level));
            cfg_dir[r]   = r[0];
            cfg_y[r]     = 11'(ROW0_Y - r * ROW_PITCH);
`ifdef LEVEL_SEQ_SPEEDUP_EN
            cfg_speed[r] = 6'(2 + int'(Level) + r);
`else
            cfg_speed[r] = 6'(2 + r);
`endif
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state           <= LOAD;
            hold_cnt        <= '0;
            win_q           <= 1'b1;
            lose_q          <= 1'b1;
            Level           <= '0;
            Lives           <= 2'(START_LIVES);
            Row_Number_Cars <= '0;
            Row_Gap_Size    <= '0;
            Row_Speed       <= '0;
            Row_Direction   <= '0;
            Row_Start_Y     <= '0;
            Row_Reload      <= 1'b0;
            Rows_Frozen     <= 1'b1;
            Game_Over       <= 1'b0;
        end else begin
            win_q      <= win;
            lose_q     <= lose;
            Row_Reload <= 1'b0;
            case (state)
                LOAD: begin
                    state           <= PLAY;
                    Row_Number_Cars <= cfg_cars;
                    Row_Gap_Size    <= cfg_gap;
                    Row_Speed       <= cfg_speed;
                    Row_Direction   <= cfg_dir;
                    Row_Start_Y     <= cfg_y;
                    Row_Reload      <= 1'b1;
                    Rows_Frozen     <= 1'b0;
                end
                PLAY: begin
                    // lose wins a tie; a simultaneous win is dropped
                    if (lose_e) begin
                        state       <= LOSE_HOLD;
                        Lives       <= Lives - 2'd1;
                        hold_cnt    <= HW'(HOLD_FRAMES - 1);
                        Rows_Frozen <= 1'b1;
                    end else if (win_e) begin
                        state       <= WIN_HOLD;
                        hold_cnt    <= HW'(HOLD_FRAMES - 1);
                        Rows_Frozen <= 1'b1;
                    end
                end
                WIN_HOLD: begin
                    if (hold_cnt == '0) begin
                        state <= LOAD;
                        Level <= Level < 3'(MAX_LEVEL) ? Level + 3'd1 : Level;
                    end else
                        hold_cnt <= hold_cnt - 1'b1;
                end
                LOSE_HOLD: begin
                    if (hold_cnt == '0) begin
                        state     <= Lives == 2'd0 ? OVER : LOAD;
                        Game_Over <= Lives == 2'd0;
                    end else
                        hold_cnt <= hold_cnt - 1'b1;
                end
                OVER: state <= OVER;
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_level_sequencer.sv
// tb_level_sequencer: directed scenario tests for level_sequencer at default parameters.
module tb_level_sequencer;
    logic              frame_clk = 0;
    logic              Reset = 1, win = 0, lose = 0;
    logic [4:0][2:0]   Row_Number_Cars;
    logic [4:0][7:0]   Row_Gap_Size;
    logic [4:0][5:0]   Row_Speed;
    logic [4:0]        Row_Direction;
    logic [4:0][10:0]  Row_Start_Y;
    logic              Row_Reload, Rows_Frozen, Game_Over;
    logic [2:0]        Level;
    logic [1:0]        Lives;
    int                compared = 0, mismatched = 0;

    level_sequencer dut (
        .frame_clk(frame_clk), .Reset(Reset), .win(win), .lose(lose),
        .Row_Number_Cars(Row_Number_Cars), .Row_Gap_Size(Row_Gap_Size),
        .Row_Speed(Row_Speed), .Row_Direction(Row_Direction),
        .Row_Start_Y(Row_Start_Y), .Row_Reload(Row_Reload),
        .Rows_Frozen(Rows_Frozen), .Level(Level), .Lives(Lives),
        .Game_Over(Game_Over)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    // one-cycle pulse on win/lose, sampled by the next edge
    task automatic pulse(input logic w, input logic l);
        win = w;
        lose = l;
        tick();
        win = 0;
        lose = 0;
    endtask

    // counts frozen cycles (including the current one) until PLAY resumes, bounded
    task automatic wait_play(output int n);
        n = 1;
        for (int i = 0; i < 200 && Rows_Frozen; i++) begin
            tick();
            if (Rows_Frozen) n++;
        end
    endtask

    task automatic test_reset();
        Reset = 1;
        repeat (3) tick();
        compared += 6;
        if (Level !== 3'd0) begin mismatched++; $display("FAIL reset_level got %0d want 0", Level); end
        if (Lives !== 2'd3) begin mismatched++; $display("FAIL reset_lives got %0d want 3", Lives); end
        if (Rows_Frozen !== 1'b1) begin mismatched++; $display("FAIL reset_frozen got %b want 1", Rows_Frozen); end
        if (Row_Reload !== 1'b0) begin mismatched++; $display("FAIL reset_reload got %b want 0", Row_Reload); end
        if (Game_Over !== 1'b0) begin mismatched++; $display("FAIL reset_over got %b want 0", Game_Over); end
        if (Row_Start_Y !== '0) begin mismatched++; $display("FAIL reset_y got %h want 0", Row_Start_Y); end
        Reset = 0;
        tick();
        compared += 7;
        if (Row_Reload !== 1'b1) begin mismatched++; $display("FAIL rel_reload got %b want 1", Row_Reload); end
        if (Rows_Frozen !== 1'b0) begin mismatched++; $display("FAIL rel_frozen got %b want 0", Rows_Frozen); end
        if (Row_Number_Cars !== {3'd3, 3'd2, 3'd2, 3'd1, 3'd1}) begin mismatched++; $display("FAIL l0_cars got %h want %h", Row_Number_Cars, {3'd3, 3'd2, 3'd2, 3'd1, 3'd1}); end
        if (Row_Gap_Size !== {5{8'd160}}) begin mismatched++; $display("FAIL l0_gap got %h want %h", Row_Gap_Size, {5{8'd160}}); end
        if (Row_Start_Y !== {11'd240, 11'd280, 11'd320, 11'd360, 11'd400}) begin mismatched++; $display("FAIL l0_y got %h", Row_Start_Y); end
        if (Row_Direction !== 5'b01010) begin mismatched++; $display("FAIL l0_dir got %b want 01010", Row_Direction); end
        if (Row_Speed !== {6'd6, 6'd5, 6'd4, 6'd3, 6'd2}) begin mismatched++; $display("FAIL l0_speed got %h", Row_Speed); end
        tick();
        compared += 2;
        if (Row_Reload !== 1'b0) begin mismatched++; $display("FAIL reload_pulse got %b want 0", Row_Reload); end
        if (Rows_Frozen !== 1'b0) begin mismatched++; $display("FAIL play_frozen got %b want 0", Rows_Frozen); end
    endtask

    task automatic test_win();
        int n;
        logic [4:0][5:0] sp;
`ifdef LEVEL_SEQ_SPEEDUP_EN
        sp = {6'd7, 6'd6, 6'd5, 6'd4, 6'd3};
`else
        sp = {6'd6, 6'd5, 6'd4, 6'd3, 6'd2};
`endif
        pulse(1, 0);
        compared += 2;
        if (Rows_Frozen !== 1'b1) begin mismatched++; $display("FAIL win_frozen got %b want 1", Rows_Frozen); end
        if (Level !== 3'd0) begin mismatched++; $display("FAIL win_level_early got %0d want 0", Level); end
        wait_play(n);
        compared += 6;
        if (n !== 61) begin mismatched++; $display("FAIL win_hold_len got %0d want 61", n); end
        if (Row_Reload !== 1'b1) begin mismatched++; $display("FAIL win_reload got %b want 1", Row_Reload); end
        if (Level !== 3'd1) begin mismatched++; $display("FAIL win_level got %0d want 1", Level); end
        if (Row_Gap_Size !== {5{8'd144}}) begin mismatched++; $display("FAIL win_gap got %h want %h", Row_Gap_Size, {5{8'd144}}); end
        if (Row_Speed !== sp) begin mismatched++; $display("FAIL win_speed got %h want %h", Row_Speed, sp); end
        if (Row_Number_Cars !== {3'd3, 3'd3, 3'd2, 3'd2, 3'd1}) begin mismatched++; $display("FAIL l1_cars got %h", Row_Number_Cars); end
    endtask

    task automatic test_simultaneous();
        int n;
        pulse(1, 1);
        compared += 3;
        if (Lives !== 2'd2) begin mismatched++; $display("FAIL sim_lives got %0d want 2", Lives); end
        if (Level !== 3'd1) begin mismatched++; $display("FAIL sim_level got %0d want 1", Level); end
        if (Rows_Frozen !== 1'b1) begin mismatched++; $display("FAIL sim_frozen got %b want 1", Rows_Frozen); end
        wait_play(n);
        compared += 2;
        if (n !== 61) begin mismatched++; $display("FAIL sim_hold_len got %0d want 61", n); end
        if (Level !== 3'd1) begin mismatched++; $display("FAIL sim_level_after got %0d want 1", Level); end
    endtask

    task automatic test_held_win();
        int n;
        win = 1;
        tick();
        wait_play(n);
        repeat (5) tick();
        compared += 2;
        if (Level !== 3'd2) begin mismatched++; $display("FAIL held_level got %0d want 2", Level); end
        if (Rows_Frozen !== 1'b0) begin mismatched++; $display("FAIL held_frozen got %b want 0", Rows_Frozen); end
        win = 0;
        tick();
    endtask

    task automatic test_saturation();
        int n;
        logic [2:0] exp_l;
        logic [4:0][5:0] sp;
`ifdef LEVEL_SEQ_SPEEDUP_EN
        sp = {6'd13, 6'd12, 6'd11, 6'd10, 6'd9};
`else
        sp = {6'd6, 6'd5, 6'd4, 6'd3, 6'd2};
`endif
        exp_l = 3'd2;
        for (int i = 0; i < 9; i++) begin
            pulse(1, 0);
            wait_play(n);
            if (exp_l < 3'd7) exp_l = exp_l + 3'd1;
            compared++;
            if (Level !== exp_l) begin mismatched++; $display("FAIL sat_level_%0d got %0d want %0d", i, Level, exp_l); end
        end
        compared += 3;
        if (Row_Gap_Size !== {5{8'd48}}) begin mismatched++; $display("FAIL sat_gap got %h want %h", Row_Gap_Size, {5{8'd48}}); end
        if (Row_Number_Cars !== {5{3'd4}}) begin mismatched++; $display("FAIL sat_cars got %h", Row_Number_Cars); end
        if (Row_Speed !== sp) begin mismatched++; $display("FAIL sat_speed got %h want %h", Row_Speed, sp); end
    endtask

    task automatic test_reset_mid_hold();
        pulse(1, 0);
        repeat (29) tick();
        Reset = 1;
        tick();
        compared += 5;
        if (Level !== 3'd0) begin mismatched++; $display("FAIL rmh_level got %0d want 0", Level); end
        if (Lives !== 2'd3) begin mismatched++; $display("FAIL rmh_lives got %0d want 3", Lives); end
        if (Rows_Frozen !== 1'b1) begin mismatched++; $display("FAIL rmh_frozen got %b want 1", Rows_Frozen); end
        if (Row_Gap_Size !== '0) begin mismatched++; $display("FAIL rmh_gap got %h want 0", Row_Gap_Size); end
        if (Game_Over !== 1'b0) begin mismatched++; $display("FAIL rmh_over got %b want 0", Game_Over); end
        Reset = 0;
        tick();
        compared += 3;
        if (Row_Reload !== 1'b1) begin mismatched++; $display("FAIL rmh_reload got %b want 1", Row_Reload); end
        if (Rows_Frozen !== 1'b0) begin mismatched++; $display("FAIL rmh_play got %b want 0", Rows_Frozen); end
        if (Row_Gap_Size !== {5{8'd160}}) begin mismatched++; $display("FAIL rmh_gap_l0 got %h", Row_Gap_Size); end
        tick();
    endtask

    task automatic test_three_losses();
        int n;
        for (int i = 0; i < 2; i++) begin
            pulse(0, 1);
            compared++;
            if (Lives !== 2'(2 - i)) begin mismatched++; $display("FAIL loss_lives_%0d got %0d want %0d", i, Lives, 2 - i); end
            wait_play(n);
            compared++;
            if (n !== 61) begin mismatched++; $display("FAIL loss_hold_%0d got %0d want 61", i, n); end
        end
        pulse(0, 1);
        repeat (59) tick();
        compared += 2;
        if (Lives !== 2'd0) begin mismatched++; $display("FAIL loss_lives_2 got %0d want 0", Lives); end
        if (Game_Over !== 1'b0) begin mismatched++; $display("FAIL over_early got %b want 0", Game_Over); end
        tick();
        compared += 2;
        if (Game_Over !== 1'b1) begin mismatched++; $display("FAIL over_set got %b want 1", Game_Over); end
        if (Rows_Frozen !== 1'b1) begin mismatched++; $display("FAIL over_frozen got %b want 1", Rows_Frozen); end
        pulse(1, 0);
        repeat (5) tick();
        pulse(0, 1);
        repeat (70) tick();
        compared += 4;
        if (Game_Over !== 1'b1) begin mismatched++; $display("FAIL over_sticky got %b want 1", Game_Over); end
        if (Rows_Frozen !== 1'b1) begin mismatched++; $display("FAIL over_frozen_late got %b want 1", Rows_Frozen); end
        if (Lives !== 2'd0) begin mismatched++; $display("FAIL over_lives got %0d want 0", Lives); end
        if (Row_Reload !== 1'b0) begin mismatched++; $display("FAIL over_reload got %b want 0", Row_Reload); end
    endtask

    initial begin
        #1;
        test_reset();
        test_win();
        test_simultaneous();
        test_held_win();
        test_saturation();
        test_reset_mid_hold();
        test_three_losses();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
